// File: rtl/force_wb_ring_node.sv
// Force write-back ring node: merges local PE write-backs with ring transit traffic,
// ejects packets for HOME_CELL and forwards the rest downstream.
module force_wb_ring_node #(
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
  parameter int WB_WIDTH          = ID_WIDTH + 3*DATA_WIDTH,
  parameter logic [3*CELL_ID_WIDTH-1:0] HOME_CELL = 9'b010_010_010,
  parameter int LOCAL_FIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT      = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WB_WIDTH-1:0] local_data,
  input  logic                local_valid,
  output logic                local_ready,
  input  logic [WB_WIDTH-1:0] ring_in_data,
  input  logic                ring_in_valid,
  output logic                ring_in_ready,
  output logic [WB_WIDTH-1:0] ring_out_data,
  output logic                ring_out_valid,
  input  logic                ring_out_ready,
  output logic [WB_WIDTH-1:0] eject_data,
  output logic                eject_valid,
  input  logic                eject_ready,
  output logic                node_idle
);
  localparam int PW       = $clog2(LOCAL_FIFO_DEPTH);
  localparam int CW       = PW + 1;
  localparam int SW       = $clog2(STARVE_LIMIT + 1);
  localparam int DEST_LSB = WB_WIDTH - ID_WIDTH + PARTICLE_ID_WIDTH;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(LOCAL_FIFO_DEPTH);

  logic [WB_WIDTH-1:0] fifo_mem_q [LOCAL_FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q;
  logic                hold_valid_q;
  logic [WB_WIDTH-1:0] hold_data_q;
  logic                ro_valid_q, ej_valid_q;
  logic [WB_WIDTH-1:0] ro_data_q, ej_data_q;
  logic [SW-1:0]       ro_starve_q, ro_starve_d, ej_starve_q, ej_starve_d;

  logic [WB_WIDTH-1:0] fifo_head;
  logic fifo_empty, fifo_full, hold_home, fifo_home;
  logic ro_free, ej_free, h_ro, f_ro, h_ej, f_ej;
  logic ro_fifo_win, ro_hold_win, ej_fifo_win, ej_hold_win;
  logic push, pop, hold_departs, hold_load;

  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FIFO_FULL);
  assign hold_home  = (hold_data_q[WB_WIDTH-1:DEST_LSB] == HOME_CELL);
  assign fifo_home  = (fifo_head[WB_WIDTH-1:DEST_LSB] == HOME_CELL);

  // Contenders per output are gated by that output register being free this cycle.
  assign ro_free = ~ro_valid_q | ring_out_ready;
  assign ej_free = ~ej_valid_q | eject_ready;
  assign h_ro    = hold_valid_q & ~hold_home & ro_free;
  assign f_ro    = ~fifo_empty  & ~fifo_home & ro_free;
  assign h_ej    = hold_valid_q &  hold_home & ej_free;
  assign f_ej    = ~fifo_empty  &  fifo_home & ej_free;

  assign ro_fifo_win = f_ro & (~h_ro | (ro_starve_q == STARVE_MAX));
  assign ro_hold_win = h_ro & ~ro_fifo_win;
  assign ej_fifo_win = f_ej & (~h_ej | (ej_starve_q == STARVE_MAX));
  assign ej_hold_win = h_ej & ~ej_fifo_win;

  assign hold_departs  = ro_hold_win | ej_hold_win;
  assign pop           = ro_fifo_win | ej_fifo_win;
  assign local_ready   = rst & ~fifo_full;
  assign push          = local_valid & local_ready;
  assign ring_in_ready = ~hold_valid_q | hold_departs;
  assign hold_load     = ring_in_valid & ring_in_ready;

  always_comb begin
    ro_starve_d = ro_starve_q;
    ej_starve_d = ej_starve_q;
    if (ro_fifo_win)                                          ro_starve_d = '0;
    else if (f_ro && ro_hold_win && ro_starve_q != STARVE_MAX) ro_starve_d = ro_starve_q + 1'b1;
    if (ej_fifo_win)                                          ej_starve_d = '0;
    else if (f_ej && ej_hold_win && ej_starve_q != STARVE_MAX) ej_starve_d = ej_starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
      ro_valid_q   <= 1'b0;
      ej_valid_q   <= 1'b0;
      ro_starve_q  <= '0;
      ej_starve_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (hold_load)         hold_valid_q <= 1'b1;
      else if (hold_departs) hold_valid_q <= 1'b0;
      if (ro_fifo_win || ro_hold_win) ro_valid_q <= 1'b1;
      else if (ring_out_ready)        ro_valid_q <= 1'b0;
      if (ej_fifo_win || ej_hold_win) ej_valid_q <= 1'b1;
      else if (eject_ready)           ej_valid_q <= 1'b0;
      ro_starve_q <= ro_starve_d;
      ej_starve_q <= ej_starve_d;
    end
  end

  // Payload registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (push)      fifo_mem_q[wr_ptr_q] <= local_data;
    if (hold_load) hold_data_q <= ring_in_data;
    if (ro_fifo_win || ro_hold_win) ro_data_q <= ro_fifo_win ? fifo_head : hold_data_q;
    if (ej_fifo_win || ej_hold_win) ej_data_q <= ej_fifo_win ? fifo_head : hold_data_q;
  end

  assign ring_out_data  = ro_data_q;
  assign ring_out_valid = ro_valid_q;
  assign eject_data     = ej_data_q;
  assign eject_valid    = ej_valid_q;
  assign node_idle      = fifo_empty & ~hold_valid_q & ~ro_valid_q & ~ej_valid_q;
endmodule

// File: tb/tb_force_wb_ring_node.sv
// Bench for force_wb_ring_node: directed scenarios plus randomized traffic against a
// queue-based reference model of the node.
module tb_force_wb_ring_node;
  localparam int WB    = 112;
  localparam int DEPTH = 4;
  localparam int LIM   = 7;
  localparam logic [8:0] HOME = 9'b010_010_010;

  logic clk = 1'b0, rst = 1'b0;
  logic [WB-1:0] local_data = '0, ring_in_data = '0;
  logic local_valid = 1'b0, ring_in_valid = 1'b0, ring_out_ready = 1'b0, eject_ready = 1'b0;
  logic local_ready, ring_in_ready, ring_out_valid, eject_valid, node_idle;
  logic [WB-1:0] ring_out_data, eject_data;

  int checks = 0, errors = 0;

  force_wb_ring_node dut (
    .clk(clk), .rst(rst),
    .local_data(local_data), .local_valid(local_valid), .local_ready(local_ready),
    .ring_in_data(ring_in_data), .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
    .ring_out_data(ring_out_data), .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
    .eject_data(eject_data), .eject_valid(eject_valid), .eject_ready(eject_ready),
    .node_idle(node_idle)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [WB-1:0] mq[$];
  bit mh_v, mro_v, mej_v, m_loc_acc, m_ring_acc;
  logic [WB-1:0] mh_d, mro_d, mej_d;
  int mst_ro, mst_ej;

  function automatic bit is_home(logic [WB-1:0] d);
    return d[WB-1 -: 9] == HOME;
  endfunction

  function automatic logic [WB-1:0] mk_pkt(bit home);
    logic [8:0] d;
    d = home ? HOME : 9'($urandom);
    if (!home && d == HOME) d = 9'h000;
    return {d, 7'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic m_reset();
    mq.delete();
    mh_v = 0; mro_v = 0; mej_v = 0; mst_ro = 0; mst_ej = 0;
    m_loc_acc = 0; m_ring_acc = 0;
  endtask

  // Who leaves this cycle: 0 = nobody, 1 = ring_out, 2 = eject.
  function automatic void m_arb(output int hgo, output int fgo);
    int hdst, fdst;
    hgo = 0; fgo = 0;
    hdst = !mh_v ? 0 : (is_home(mh_d) ? 2 : 1);
    fdst = (mq.size() == 0) ? 0 : (is_home(mq[0]) ? 2 : 1);
    for (int o = 1; o <= 2; o++) begin
      bit fr;
      int st;
      fr = (o == 1) ? (!mro_v || ring_out_ready) : (!mej_v || eject_ready);
      st = (o == 1) ? mst_ro : mst_ej;
      if (fr) begin
        if (hdst == o && fdst == o) begin
          if (st == LIM) fgo = o; else hgo = o;
        end else if (hdst == o) hgo = o;
        else if (fdst == o) fgo = o;
      end
    end
  endfunction

  // Advance one clock: predict from current inputs, commit after the edge, return at negedge.
  task automatic cyc();
    int hgo, fgo, fdst;
    bit lacc, racc, ror, ejr;
    logic [WB-1:0] rin, lin, hd, fh;
    m_arb(hgo, fgo);
    fdst = (mq.size() == 0) ? 0 : (is_home(mq[0]) ? 2 : 1);
    lacc = local_valid && (mq.size() < DEPTH);
    racc = ring_in_valid && (!mh_v || hgo != 0);
    rin = ring_in_data; lin = local_data; ror = ring_out_ready; ejr = eject_ready;
    hd = mh_d; fh = (mq.size() != 0) ? mq[0] : '0;
    @(posedge clk);
    if (fgo == 1) mst_ro = 0; else if (fdst == 1 && hgo == 1 && mst_ro < LIM) mst_ro++;
    if (fgo == 2) mst_ej = 0; else if (fdst == 2 && hgo == 2 && mst_ej < LIM) mst_ej++;
    if (hgo == 1) begin mro_v = 1; mro_d = hd; end
    else if (fgo == 1) begin mro_v = 1; mro_d = fh; end
    else if (ror) mro_v = 0;
    if (hgo == 2) begin mej_v = 1; mej_d = hd; end
    else if (fgo == 2) begin mej_v = 1; mej_d = fh; end
    else if (ejr) mej_v = 0;
    if (racc) begin mh_v = 1; mh_d = rin; end
    else if (hgo != 0) mh_v = 0;
    if (fgo != 0) void'(mq.pop_front());
    if (lacc) mq.push_back(lin);
    m_loc_acc = lacc; m_ring_acc = racc;
    @(negedge clk);
  endtask

  task automatic drain();
    local_valid = 0; ring_in_valid = 0; ring_out_ready = 1; eject_ready = 1;
    repeat (8) cyc();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 0; m_reset();
    local_valid = 1; ring_in_valid = 1; local_data = mk_pkt(0); ring_in_data = mk_pkt(1);
    ring_out_ready = 1; eject_ready = 1;
    repeat (3) @(negedge clk);
    checks++; if (local_ready !== 1'b0) begin errors++; $display("FAIL reset_local_ready got=%b exp=0", local_ready); end
    checks++; if (ring_out_valid !== 1'b0) begin errors++; $display("FAIL reset_ring_out_valid got=%b exp=0", ring_out_valid); end
    checks++; if (eject_valid !== 1'b0) begin errors++; $display("FAIL reset_eject_valid got=%b exp=0", eject_valid); end
    checks++; if (node_idle !== 1'b1) begin errors++; $display("FAIL reset_node_idle got=%b exp=1", node_idle); end
    local_valid = 0; ring_in_valid = 0;
    rst = 1;
    #1;
    checks++; if (local_ready !== 1'b1) begin errors++; $display("FAIL release_local_ready got=%b exp=1", local_ready); end
    @(negedge clk);
  endtask

  task automatic test_local_to_ring();
    logic [WB-1:0] p;
    drain();
    p = {3'b011, 3'b010, 3'b010, 7'h15, 32'h3F800000, 32'h40000000, 32'hC0400000};
    local_data = p; local_valid = 1;
    cyc();
    local_valid = 0;
    checks++; if (ring_out_valid !== 1'b0) begin errors++; $display("FAIL local_early_valid got=%b exp=0", ring_out_valid); end
    cyc();
    checks++; if (ring_out_valid !== 1'b1) begin errors++; $display("FAIL local_lat2_valid got=%b exp=1", ring_out_valid); end
    checks++; if (ring_out_data !== p) begin errors++; $display("FAIL local_data got=%h exp=%h", ring_out_data, p); end
    checks++; if (eject_valid !== 1'b0) begin errors++; $display("FAIL local_no_eject got=%b exp=0", eject_valid); end
    cyc();
    checks++; if (node_idle !== 1'b1) begin errors++; $display("FAIL local_idle_after got=%b exp=1", node_idle); end
  endtask

  task automatic test_eject_stall();
    logic [WB-1:0] p1, p2, p3;
    drain();
    p1 = mk_pkt(1); p2 = mk_pkt(1); p3 = mk_pkt(1);
    eject_ready = 0;
    ring_in_data = p1; ring_in_valid = 1;
    cyc();
    ring_in_valid = 0;
    cyc();
    checks++; if (eject_valid !== 1'b1 || eject_data !== p1) begin errors++; $display("FAIL eject_lat2 got=%b/%h exp=1/%h", eject_valid, eject_data, p1); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (eject_valid !== 1'b1 || eject_data !== p1) begin errors++; $display("FAIL eject_stable[%0d] got=%b/%h exp=1/%h", i, eject_valid, eject_data, p1); end
    end
    ring_in_data = p2; ring_in_valid = 1; #1;
    checks++; if (ring_in_ready !== 1'b1) begin errors++; $display("FAIL hold_empty_ready got=%b exp=1", ring_in_ready); end
    cyc();
    ring_in_data = p3; #1;
    checks++; if (ring_in_ready !== 1'b0) begin errors++; $display("FAIL hold_full_ready got=%b exp=0", ring_in_ready); end
    cyc();
    checks++; if (ring_in_ready !== 1'b0 || eject_data !== p1) begin errors++; $display("FAIL hold_full_stay got=%b/%h exp=0/%h", ring_in_ready, eject_data, p1); end
    eject_ready = 1; #1;
    checks++; if (ring_in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got=%b exp=1", ring_in_ready); end
    cyc();
    ring_in_valid = 0;
    checks++; if (eject_valid !== 1'b1 || eject_data !== p2) begin errors++; $display("FAIL eject_p2 got=%b/%h exp=1/%h", eject_valid, eject_data, p2); end
    cyc();
    checks++; if (eject_valid !== 1'b1 || eject_data !== p3) begin errors++; $display("FAIL eject_p3 got=%b/%h exp=1/%h", eject_valid, eject_data, p3); end
    cyc();
    checks++; if (eject_valid !== 1'b0 || node_idle !== 1'b1) begin errors++; $display("FAIL eject_drained got=%b/%b exp=0/1", eject_valid, node_idle); end
  endtask

  task automatic test_contention();
    logic [WB-1:0] r[$], obs[$], expq[$], lp;
    int ridx, lacc_c, lseen_c;
    bit racc, lacc;
    drain();
    for (int i = 0; i < 20; i++) r.push_back(mk_pkt(0));
    lp = mk_pkt(0);
    ridx = 0; lacc_c = -1; lseen_c = -1;
    for (int c = 0; c < 32; c++) begin
      if (ring_out_valid) begin
        obs.push_back(ring_out_data);
        if (ring_out_data === lp) lseen_c = c;
      end
      ring_in_valid = (ridx < 20);
      ring_in_data  = (ridx < 20) ? r[ridx] : '0;
      if (c == 3) begin local_valid = 1; local_data = lp; end
      #1;
      racc = ring_in_valid && ring_in_ready;
      lacc = local_valid && local_ready;
      cyc();
      if (racc) ridx++;
      if (lacc) begin lacc_c = c; local_valid = 0; end
    end
    ring_in_valid = 0;
    for (int i = 0; i < 10; i++) expq.push_back(r[i]);
    expq.push_back(lp);
    for (int i = 10; i < 20; i++) expq.push_back(r[i]);
    checks++; if (lacc_c !== 3) begin errors++; $display("FAIL starve_local_accept got=%0d exp=3", lacc_c); end
    checks++; if (lseen_c !== lacc_c + 9) begin errors++; $display("FAIL starve_local_cycle got=%0d exp=%0d", lseen_c, lacc_c + 9); end
    checks++; if (obs.size() !== expq.size()) begin errors++; $display("FAIL starve_count got=%0d exp=%0d", obs.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== expq[i]) begin errors++; $display("FAIL starve_order[%0d] got=%h exp=%h", i, obs[i], expq[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [WB-1:0] p[6], obs[$];
    int idx;
    bit acc;
    drain();
    for (int i = 0; i < 6; i++) p[i] = mk_pkt(0);
    ring_out_ready = 0; idx = 0;
    local_valid = 1; local_data = p[0];
    for (int c = 0; c < 10; c++) begin
      #1; acc = local_ready;
      cyc();
      if (acc) idx++;
      local_data = p[(idx < 6) ? idx : 5];
    end
    checks++; if (idx !== 5) begin errors++; $display("FAIL bp_accepts got=%0d exp=5", idx); end
    checks++; if (local_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", local_ready); end
    checks++; if (ring_out_valid !== 1'b1 || ring_out_data !== p[0]) begin errors++; $display("FAIL bp_out_hold got=%b/%h exp=1/%h", ring_out_valid, ring_out_data, p[0]); end
    ring_out_ready = 1;
    for (int c = 0; c < 15; c++) begin
      if (ring_out_valid) obs.push_back(ring_out_data);
      #1; acc = local_valid && local_ready;
      cyc();
      if (acc) begin idx++; local_valid = 0; end
    end
    checks++; if (obs.size() !== 6) begin errors++; $display("FAIL bp_out_count got=%0d exp=6", obs.size()); end
    for (int i = 0; i < 6 && i < obs.size(); i++) begin
      checks++; if (obs[i] !== p[i]) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, obs[i], p[i]); end
    end
  endtask

  task automatic test_parallel();
    logic [WB-1:0] h, l;
    drain();
    h = mk_pkt(1); l = mk_pkt(0);
    ring_in_data = h; ring_in_valid = 1; local_data = l; local_valid = 1;
    #1;
    checks++; if (ring_in_ready !== 1'b1 || local_ready !== 1'b1) begin errors++; $display("FAIL par_ready got=%b%b exp=11", ring_in_ready, local_ready); end
    cyc();
    ring_in_valid = 0; local_valid = 0;
    cyc();
    checks++; if (ring_out_valid !== 1'b1 || ring_out_data !== l) begin errors++; $display("FAIL par_ring_out got=%b/%h exp=1/%h", ring_out_valid, ring_out_data, l); end
    checks++; if (eject_valid !== 1'b1 || eject_data !== h) begin errors++; $display("FAIL par_eject got=%b/%h exp=1/%h", eject_valid, eject_data, h); end
    checks++; if (dut.ro_starve_q !== 3'd0 || dut.ej_starve_q !== 3'd0) begin errors++; $display("FAIL par_starve got=%0d/%0d exp=0/0", dut.ro_starve_q, dut.ej_starve_q); end
    cyc();
  endtask

  task automatic test_random();
    int hgo, fgo;
    bit exp_idle;
    drain();
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) begin
        rst = 0; #1;
        checks++; if (ring_out_valid !== 1'b0 || eject_valid !== 1'b0 || node_idle !== 1'b1 || local_ready !== 1'b0) begin
          errors++; $display("FAIL rnd_midreset got=%b%b%b%b exp=0010", ring_out_valid, eject_valid, node_idle, local_ready);
        end
        m_reset(); local_valid = 0; ring_in_valid = 0;
        @(negedge clk); rst = 1;
      end
      exp_idle = (mq.size() == 0) && !mh_v && !mro_v && !mej_v;
      checks++; if (ring_out_valid !== mro_v || (mro_v && ring_out_data !== mro_d)) begin
        errors++; $display("FAIL rnd_ring_out c=%0d got=%b/%h exp=%b/%h", c, ring_out_valid, ring_out_data, mro_v, mro_d);
      end
      checks++; if (eject_valid !== mej_v || (mej_v && eject_data !== mej_d)) begin
        errors++; $display("FAIL rnd_eject c=%0d got=%b/%h exp=%b/%h", c, eject_valid, eject_data, mej_v, mej_d);
      end
      checks++; if (node_idle !== exp_idle) begin errors++; $display("FAIL rnd_idle c=%0d got=%b exp=%b", c, node_idle, exp_idle); end
      if (!(local_valid && !m_loc_acc)) begin
        local_valid = ($urandom_range(0, 2) != 0); local_data = mk_pkt($urandom_range(0, 1) == 1);
      end
      if (!(ring_in_valid && !m_ring_acc)) begin
        ring_in_valid = ($urandom_range(0, 2) != 0); ring_in_data = mk_pkt($urandom_range(0, 1) == 1);
      end
      ring_out_ready = ($urandom_range(0, 3) != 0);
      eject_ready    = ($urandom_range(0, 3) != 0);
      #1;
      m_arb(hgo, fgo);
      checks++; if (ring_in_ready !== (!mh_v || hgo != 0)) begin errors++; $display("FAIL rnd_ring_in_ready c=%0d got=%b", c, ring_in_ready); end
      checks++; if (local_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_local_ready c=%0d got=%b", c, local_ready); end
      cyc();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_local_to_ring();
    test_eject_stall();
    test_contention();
    test_backpressure();
    test_parallel();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
